burst_element_packer: RTL and testbench

- Sits directly downstream of the AXI array burst reader.
- Consumes its element packets: up to NUM_PARALLEL_ELEMENTS elements per packet, with a start lane (offset), a length and a last flag.
- Repacks them into dense, lane-0-aligned output words of exactly NUM_PARALLEL_ELEMENTS elements. Only the final word of a burst may be partial.
- Lets later compute stages ignore misaligned burst starts and short tails.

---
 rtl/burst_element_packer.sv | 179 +++++++++++++++++
 tb/tb_burst_element_packer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/burst_element_packer.sv
// Repacks offset/length element packets from the burst reader into dense,
// lane-0-aligned words of NUM_PARALLEL_ELEMENTS elements; only a burst's final word may be short.
module burst_element_packer #(
  parameter int ELEM_WIDTH            = 16,
  parameter int NUM_PARALLEL_ELEMENTS = 4
) (
  input  logic                                            aclk,
  input  logic                                            areset,
  input  logic                                            in_valid,
  input  logic [NUM_PARALLEL_ELEMENTS*ELEM_WIDTH-1:0]     in_elements,
  input  logic [$clog2(NUM_PARALLEL_ELEMENTS)-1:0]        in_chunk_offset,
  input  logic [$clog2(NUM_PARALLEL_ELEMENTS+1)-1:0]      in_chunk_length,
  input  logic                                            in_last,
  output logic                                            out_valid,
  output logic [NUM_PARALLEL_ELEMENTS*ELEM_WIDTH-1:0]     out_elements,
  output logic [$clog2(NUM_PARALLEL_ELEMENTS+1)-1:0]      out_count,
  output logic                                            out_last,
  output logic                                            error
);

  localparam int N     = NUM_PARALLEL_ELEMENTS;
  localparam int EW    = ELEM_WIDTH;
  localparam int LEN_W = $clog2(N + 1);
  localparam int TOT_W = $clog2(2 * N);
  localparam int IDX_W = TOT_W + 1;
  localparam int SEQ   = 2 * N - 1;

  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [EW-1:0]      hold_q [N-1];
  logic [EW-1:0]      hold_d [N-1];
  logic [TOT_W-1:0]   hold_count_q, hold_count_d;
  logic               error_q, error_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [LEN_W-1:0]   out_count_q, out_count_d;
  logic [N*EW-1:0]    out_elements_q, out_elements_d;

  logic [EW-1:0]      in_lane [N];
  logic [EW-1:0]      seq [SEQ];
  logic [IDX_W-1:0]   off_ext, len_ext;
  logic [TOT_W-1:0]   total;
  logic               legal;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign in_lane[gi] = in_elements[gi*EW +: EW];
  end

  assign off_ext = IDX_W'(in_chunk_offset);
  assign len_ext = IDX_W'(in_chunk_length);
  assign legal   = (len_ext != '0) && ((off_ext + len_ext) <= IDX_W'(N));
  assign total   = hold_count_q + TOT_W'(in_chunk_length);

  // seq = held elements followed by the packet's valid lanes; positions past total read as 0.
  for (genvar gi = 0; gi < SEQ; gi++) begin : g_seq
    logic [IDX_W-1:0] rel;
    logic [IDX_W-1:0] src;
    logic             from_hold;
    logic             from_in;
    logic [EW-1:0]    in_pick;
    logic [EW-1:0]    hold_pick;

    assign from_hold = IDX_W'(gi) < IDX_W'(hold_count_q);
    assign rel       = IDX_W'(gi) - IDX_W'(hold_count_q);
    assign from_in   = !from_hold && (rel < len_ext);
    assign src       = off_ext + rel;

    always_comb begin
      in_pick = '0;
      for (int e = 0; e < N; e++) begin
        if (src == IDX_W'(e)) begin
          in_pick = in_lane[e];
        end
      end
    end

    if (gi < N - 1) begin : g_hold
      assign hold_pick = hold_q[gi];
    end else begin : g_no_hold
      assign hold_pick = '0;
    end

    assign seq[gi] = from_hold ? hold_pick : (from_in ? in_pick : '0);
  end

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    hold_count_d   = hold_count_q;
    error_d        = error_q;
    out_valid_d    = 1'b0;
    out_last_d     = 1'b0;
    out_count_d    = '0;
    out_elements_d = '0;

    if (state_q == FLUSH) begin
      // The flush word always goes out; a packet arriving now cannot be absorbed.
      out_valid_d  = 1'b1;
      out_last_d   = 1'b1;
      out_count_d  = LEN_W'(hold_count_q);
      for (int i = 0; i < N - 1; i++) begin
        if (TOT_W'(i) < hold_count_q) begin
          out_elements_d[i*EW +: EW] = hold_q[i];
        end
      end
      hold_count_d = '0;
      state_d      = ACCUM;
      if (in_valid) begin
        error_d = 1'b1;
      end
    end else if (in_valid) begin
      if (!legal) begin
        error_d = 1'b1;
      end else if (total >= TOT_W'(N)) begin
        out_valid_d = 1'b1;
        out_count_d = LEN_W'(N);
        for (int i = 0; i < N; i++) begin
          out_elements_d[i*EW +: EW] = seq[i];
        end
        for (int j = 0; j < N - 1; j++) begin
          hold_d[j] = seq[N + j];
        end
        hold_count_d = total - TOT_W'(N);
        if (in_last && (total == TOT_W'(N))) begin
          out_last_d = 1'b1;
        end else if (in_last) begin
          state_d = FLUSH;
        end
      end else if (in_last) begin
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        out_count_d = LEN_W'(total);
        for (int i = 0; i < N; i++) begin
          out_elements_d[i*EW +: EW] = seq[i];
        end
        hold_count_d = '0;
      end else begin
        for (int j = 0; j < N - 1; j++) begin
          hold_d[j] = seq[j];
        end
        hold_count_d = total;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q        <= ACCUM;
      hold_count_q   <= '0;
      error_q        <= 1'b0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      out_count_q    <= '0;
      out_elements_q <= '0;
      for (int j = 0; j < N - 1; j++) begin
        hold_q[j] <= '0;
      end
    end else begin
      state_q        <= state_d;
      hold_count_q   <= hold_count_d;
      error_q        <= error_d;
      out_valid_q    <= out_valid_d;
      out_last_q     <= out_last_d;
      out_count_q    <= out_count_d;
      out_elements_q <= out_elements_d;
      for (int j = 0; j < N - 1; j++) begin
        hold_q[j] <= hold_d[j];
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_count    = out_count_q;
  assign out_elements = out_elements_q;
  assign error        = error_q;

endmodule

// File: tb/tb_burst_element_packer.sv
// Randomized and directed bench for burst_element_packer; a queue-based element model
// predicts each output word and a negedge monitor compares against it.
module tb_burst_element_packer;

  localparam int N  = 4;
  localparam int EW = 16;

  logic            aclk = 1'b0;
  logic            areset = 1'b1;
  logic            in_valid = 1'b0;
  logic [N*EW-1:0] in_elements = '0;
  logic [1:0]      in_chunk_offset = '0;
  logic [2:0]      in_chunk_length = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic [N*EW-1:0] out_elements;
  logic [2:0]      out_count;
  logic            out_last;
  logic            error;

  burst_element_packer #(.ELEM_WIDTH(EW), .NUM_PARALLEL_ELEMENTS(N)) dut (
    .aclk(aclk), .areset(areset), .in_valid(in_valid), .in_elements(in_elements),
    .in_chunk_offset(in_chunk_offset), .in_chunk_length(in_chunk_length), .in_last(in_last),
    .out_valid(out_valid), .out_elements(out_elements), .out_count(out_count),
    .out_last(out_last), .error(error)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int              cyc;
    logic [N*EW-1:0] elems;
    int              count;
    bit              last;
  } exp_t;

  exp_t          exp_q[$];
  logic [EW-1:0] pend_q[$];
  bit            exp_err = 1'b0;
  int            flush_edge = -1;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  localparam logic [EW-1:0] X = 16'hDEAD;

  function automatic logic [N*EW-1:0] mk(input logic [EW-1:0] a, input logic [EW-1:0] b,
                                         input logic [EW-1:0] c, input logic [EW-1:0] d);
    return {d, c, b, a};
  endfunction

  // Model: elements stream into a FIFO; every N collected form a word, a last packet drains the rest.
  function automatic void model(input bit v, input logic [N*EW-1:0] el, input int off,
                                input int len, input bit last, input bit rst);
    exp_t e;
    if (rst) begin
      pend_q.delete();
      while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
      flush_edge = -1;
      exp_err    = 1'b0;
      return;
    end
    if (!v) return;
    if (cyc == flush_edge) begin
      exp_err = 1'b1;
      return;
    end
    if (len == 0 || off + len > N) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = off; i < off + len; i++) pend_q.push_back(el[i*EW +: EW]);
    if (pend_q.size() >= N) begin
      e.cyc = cyc; e.elems = '0; e.count = N;
      for (int i = 0; i < N; i++) e.elems[i*EW +: EW] = pend_q.pop_front();
      e.last = last && (pend_q.size() == 0);
      exp_q.push_back(e);
      if (last && pend_q.size() > 0) begin
        e.cyc = cyc + 1; e.elems = '0; e.count = pend_q.size(); e.last = 1'b1;
        for (int i = 0; i < e.count; i++) e.elems[i*EW +: EW] = pend_q[i];
        exp_q.push_back(e);
        flush_edge = cyc + 1;
        pend_q.delete();
      end
    end else if (last) begin
      e.cyc = cyc; e.elems = '0; e.count = pend_q.size(); e.last = 1'b1;
      for (int i = 0; i < e.count; i++) e.elems[i*EW +: EW] = pend_q[i];
      exp_q.push_back(e);
      pend_q.delete();
    end
  endfunction

  task automatic step(input bit v, input logic [N*EW-1:0] el, input int off, input int len,
                      input bit last, input bit rst);
    #1;
    in_valid        = v;
    in_elements     = el;
    in_chunk_offset = off[1:0];
    in_chunk_length = len[2:0];
    in_last         = last;
    areset          = rst;
    @(posedge aclk);
    cyc++;
    model(v, el, off, len, last, rst);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, {$urandom, $urandom}, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic rst_pulse();
    step(1'b0, '0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic rand_traffic(input int npkts, input bit allow_err);
    int r, off, len;
    bit last;
    for (int k = 0; k < npkts; k++) begin
      if (!allow_err && flush_edge == cyc + 1) begin
        idle(1);
        continue;
      end
      r = $urandom_range(0, 99);
      if (r < 15) begin
        idle(1);
        continue;
      end
      off  = $urandom_range(0, N - 1);
      len  = $urandom_range(1, N - off);
      if (allow_err && r >= 95) len = (r == 99) ? 0 : $urandom_range(N - off + 1, 7);
      last = ($urandom_range(0, 3) == 0);
      step(1'b1, {$urandom, $urandom}, off, len, last, 1'b0);
    end
  endtask

  // Monitor: compares every cycle after the first edge against the model's queue.
  always @(negedge aclk) begin
    if (cyc >= 1) begin
      checks++;
      if (error !== exp_err) begin
        failures++;
        $display("FAIL error cyc=%0d got=%b want=%b", cyc, error, exp_err);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL missing_word cyc=%0d got=none want=%h", exp_q[0].cyc, exp_q[0].elems);
        void'(exp_q.pop_front());
      end
      checks++;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          failures++;
          $display("FAIL unexpected_word cyc=%0d got=%h count=%0d want=none", cyc, out_elements, out_count);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("word cyc=%0d elems=%h count=%0d last=%b", cyc, out_elements, out_count, out_last);
          if (out_elements !== e.elems || out_count !== 3'(e.count) || out_last !== e.last) begin
            failures++;
            $display("FAIL word cyc=%0d got=%h/%0d/%b want=%h/%0d/%b", cyc, out_elements,
                     out_count, out_last, e.elems, e.count, e.last);
          end
        end
      end else if (out_valid !== 1'b0 || out_elements !== '0 || out_count !== 3'd0 || out_last !== 1'b0) begin
        failures++;
        $display("FAIL idle cyc=%0d got=%b/%h/%0d/%b want=0/0/0/0", cyc, out_valid, out_elements, out_count, out_last);
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        failures++;
        $display("FAIL missing_word cyc=%0d got=none want=%h", cyc, exp_q[0].elems);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_pulse();
    rst_pulse();
    // Aligned burst
    step(1'b1, mk(0, 1, 2, 3), 0, 4, 1'b0, 1'b0);
    step(1'b1, mk(4, 5, 6, 7), 0, 4, 1'b0, 1'b0);
    step(1'b1, mk(8, 9, 10, 11), 0, 4, 1'b1, 1'b0);
    idle(2);
    // Misaligned start
    step(1'b1, mk(X, X, 16'hA, 16'hB), 2, 2, 1'b0, 1'b0);
    step(1'b1, mk(16'hC, 16'hD, 16'hE, 16'hF), 0, 4, 1'b0, 1'b0);
    step(1'b1, mk(16'h1A, X, X, X), 0, 1, 1'b1, 1'b0);
    idle(2);
    // Leftover flush
    step(1'b1, mk(X, 1, 2, 3), 1, 3, 1'b0, 1'b0);
    step(1'b1, mk(4, 5, 6, 7), 0, 4, 1'b1, 1'b0);
    idle(2);
    // Single element in the top lane
    step(1'b1, mk(X, X, X, 16'h55AA), 3, 1, 1'b1, 1'b0);
    idle(2);
    // Illegal packet, then a legal burst still packs
    step(1'b1, mk(X, X, X, X), 3, 2, 1'b0, 1'b0);
    idle(1);
    step(1'b1, mk(21, 22, 23, 24), 0, 4, 1'b0, 1'b0);
    step(1'b1, mk(25, X, X, X), 0, 1, 1'b1, 1'b0);
    idle(2);
    rst_pulse();
    // Packet collides with the flush cycle
    step(1'b1, mk(X, 1, 2, 3), 1, 3, 1'b0, 1'b0);
    step(1'b1, mk(4, 5, 6, 7), 0, 4, 1'b1, 1'b0);
    step(1'b1, mk(31, 32, 33, 34), 0, 4, 1'b1, 1'b0);
    idle(2);
    rst_pulse();
    // Reset mid-burst discards held elements
    step(1'b1, mk(1, 2, X, X), 0, 2, 1'b0, 1'b0);
    rst_pulse();
    step(1'b1, mk(9, 9, 9, 9), 0, 4, 1'b1, 1'b0);
    idle(2);
    // Random legal traffic, then random traffic with protocol violations
    rand_traffic(400, 1'b0);
    idle(3);
    rst_pulse();
    rand_traffic(200, 1'b1);
    idle(4);
    @(negedge aclk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d_pending want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
